relu_norm: RTL
==============

RELU_NORM -- requirements
Module: relu_norm

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 256, giving neurons per layer; power of two, >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, giving the activation width; signed Q16.16 input, unsigned Q16.16 output.
REQ-003 SHALL use a single clock and a synchronous, active-high reset; no other clock or reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  reset.
REQ-006 Port: start  input  1  begins one layer pass.
REQ-007 Port: busy  output  1  high whenever state != IDLE.
REQ-008 Port: in_valid / in_ready / in_data  input / output / input  1 / 1 / DATA_WIDTH  pre-activation stream from the MAC unit; in_data is signed.
REQ-009 Port: buf_clear  output  1  clear pulse to the activation buffer.
REQ-010 Port: buf_we / buf_waddr / buf_wdata  output  1 / $clog2(NUM_NEURONS) / DATA_WIDTH  activation buffer write port.
REQ-011 Port: done  output  1  one-cycle pass-complete pulse.
REQ-012 Port: goodness / goodness_valid  output  64 / 1  layer sum of squares in unsigned Q32.32 (see REQ-030).

Function
REQ-013 States: IDLE, CLEAR, ACCUM, SHIFT, WRITE, DONE.
REQ-014 IDLE: start=1 -> CLEAR; start is ignored in every other state.
REQ-015 CLEAR: lasts one cycle; buf_clear=1; accumulator and count zeroed; goodness_valid=0; -> ACCUM.
REQ-016 ACCUM: in_ready=1; in_ready=0 in all other states.
REQ-017 A handshake is in_valid & in_ready; on each handshake, r = (in_data < 0) ? 0 : in_data.
REQ-018 On each handshake, r is stored to local[count] and count increments.
REQ-019 On each handshake, acc += r*r as a 64-bit unsigned value, saturating at 2^64-1.
REQ-020 After the NUM_NEURONS-th handshake -> SHIFT; inputs are accepted in arrival order with no gaps required.
REQ-021 SHIFT: lasts one cycle; L = index of the highest set bit of acc; k = (acc != 0 && L >= 32) ? (L-32)>>1 : 0, so k <= 15; -> WRITE.
REQ-022 WRITE: NUM_NEURONS consecutive cycles, buf_we=1, buf_waddr = 0..NUM_NEURONS-1 ascending, buf_wdata = local[addr] logically shifted right by k; -> DONE.
REQ-023 DONE: lasts one cycle; done=1; goodness = acc; goodness_valid=1; -> IDLE.
REQ-024 goodness and goodness_valid are held until the next CLEAR.
REQ-025 Latency with in_valid held high and start at cycle t: buf_clear at t+1, accepts at t+2..t+N+1, SHIFT at t+N+2, writes at t+N+3..t+2N+2, done at t+2N+3.
REQ-026 buf_clear, buf_we and done are never high in the same cycle.
REQ-027 buf_we is high exactly NUM_NEURONS cycles per pass.

Reset
REQ-028 rst=1 at a clock edge -> next cycle: state IDLE, all outputs 0, count/acc/k = 0; local storage need not be cleared.
REQ-029 Reset asserted mid-pass (any state) aborts the pass: no further buf_we, no done pulse; a subsequent start runs a complete pass normally.

Configuration
REQ-030 Macro RELU_NORM_GOODNESS_EN: defined -> goodness/goodness_valid ports exist and behave per REQ-023/024; undefined -> both ports are absent, and acc is used only for k.

Verification
REQ-031 NUM_NEURONS=4, inputs all 0x00010000 -> acc=2^34, k=1, writes 0x00008000 to addr 0..3, goodness=0x0000000400000000.
REQ-032 NUM_NEURONS=4, inputs {0xFFFF0000, 0x00020000, 0xFFFD0000, 0} -> writes {0, 0x00010000, 0, 0}; goodness=0x0000000400000000.
REQ-033 NUM_NEURONS=4, inputs all 0x00000100 -> acc=2^18, k=0, writes 0x00000100 x4.
REQ-034 NUM_NEURONS=8, inputs all 0x7FFFFFFF -> acc saturates to 0xFFFFFFFFFFFFFFFF, k=15, writes 0x0000FFFF x8.
REQ-035 in_valid toggled every other cycle with REQ-031 data -> identical writes; done delayed by 3 cycles; no accept while in_valid=0.
REQ-036 rst pulsed during the 2nd WRITE cycle -> buf_we=0 and busy=0 next cycle, no done; a new start then completes per REQ-025.

Source files
------------

// File: rtl/relu_norm.sv
// ReLU + goodness-normalise stage for one forward-forward layer pass.
// Optional RELU_NORM_GOODNESS_EN exposes the Q32.32 sum of squares.
module relu_norm #(
  parameter int NUM_NEURONS = 256,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           buf_clear,
  output logic                           buf_we,
  output logic [$clog2(NUM_NEURONS)-1:0] buf_waddr,
  output logic [DATA_WIDTH-1:0]          buf_wdata,
  output logic                           done
`ifdef RELU_NORM_GOODNESS_EN
  ,
  output logic [63:0]                    goodness,
  output logic                           goodness_valid
`endif
);

  localparam int AW = $clog2(NUM_NEURONS);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_SHIFT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0]         r_count;
  logic [63:0]           r_acc;
  logic [3:0]            r_k;
  logic [DATA_WIDTH-1:0] r_local [NUM_NEURONS];

`ifdef RELU_NORM_GOODNESS_EN
  logic [63:0] r_good;
  logic        r_good_vld;
`endif

  logic                  w_hs;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_relu;
  logic [PW-1:0]         w_relu_x;
  logic [PW-1:0]         w_sq;
  logic [63:0]           w_sq64;
  logic [64:0]           w_sum;
  logic [63:0]           w_acc_nxt;
  logic [5:0]            w_msb;
  logic [5:0]            w_msb_off;
  logic [3:0]            w_k;

  assign w_hs   = in_valid & in_ready;
  assign w_last = (r_count == LAST);

  // Negative pre-activations clamp to zero; the sign bit is then clear.
  assign w_relu   = in_data[DATA_WIDTH-1] ? '0 : in_data;
  assign w_relu_x = {{DATA_WIDTH{1'b0}}, w_relu};
  assign w_sq     = w_relu_x * w_relu_x;
  assign w_sq64   = 64'(w_sq);

  assign w_sum     = {1'b0, r_acc} + {1'b0, w_sq64};
  assign w_acc_nxt = w_sum[64] ? {64{1'b1}} : w_sum[63:0];

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < 64; i++) begin
      if (r_acc[i]) w_msb = 6'(i);
    end
  end

  // Halving the exponent above 2^32 roughly normalises by sqrt(goodness).
  assign w_msb_off = w_msb - 6'd32;
  assign w_k = (w_msb >= 6'd32) ? w_msb_off[4:1] : 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    in_ready  = 1'b0;
    buf_clear = 1'b0;
    buf_we    = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        busy      = 1'b1;
        buf_clear = 1'b1;
        w_next    = S_ACCUM;
      end
      S_ACCUM: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (w_hs && w_last) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        busy   = 1'b1;
        w_next = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        buf_we = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign buf_waddr = buf_we ? r_count : '0;
  assign buf_wdata = buf_we ? (r_local[r_count] >> r_k) : '0;

  // Count wraps to zero after the last neuron, ready for the write sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_acc   <= '0;
      r_k     <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_count <= '0;
          r_acc   <= '0;
        end
        S_ACCUM: begin
          if (w_hs) begin
            r_count <= r_count + AW'(1);
            r_acc   <= w_acc_nxt;
          end
        end
        S_SHIFT: begin
          r_k <= w_k;
        end
        S_WRITE: begin
          r_count <= r_count + AW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) r_local[r_count] <= w_relu;
  end

`ifdef RELU_NORM_GOODNESS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_good     <= '0;
      r_good_vld <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_good     <= '0;
      r_good_vld <= 1'b0;
    end else if (r_state == S_WRITE && w_last) begin
      r_good     <= r_acc;
      r_good_vld <= 1'b1;
    end
  end

  assign goodness       = r_good;
  assign goodness_valid = r_good_vld;
`endif

endmodule
